// File: rtl/id_decode_queue_pkg.sv
// Shared constants for the IF/ID instruction queue: opcodes, function codes,
// class bit positions and the predecode/entry payload structs.
package id_decode_queue_pkg;

  localparam int unsigned XLEN  = 32;
  localparam int unsigned REG_W = 5;
  localparam int unsigned CLS_W = 4;

  localparam int unsigned CLS_BRANCH = 0;
  localparam int unsigned CLS_LOAD   = 1;
  localparam int unsigned CLS_STORE  = 2;
  localparam int unsigned CLS_MDU    = 3;

  localparam logic [5:0] OP_SPECIAL  = 6'h00;
  localparam logic [5:0] OP_REGIMM   = 6'h01;
  localparam logic [5:0] OP_J        = 6'h02;
  localparam logic [5:0] OP_JAL      = 6'h03;
  localparam logic [5:0] OP_BEQ      = 6'h04;
  localparam logic [5:0] OP_BNE      = 6'h05;
  localparam logic [5:0] OP_BLEZ     = 6'h06;
  localparam logic [5:0] OP_BGTZ     = 6'h07;
  localparam logic [5:0] OP_LUI      = 6'h0F;
  localparam logic [5:0] OP_COP0     = 6'h10;
  localparam logic [5:0] OP_SPECIAL2 = 6'h1C;
  localparam logic [5:0] OP_LB       = 6'h20;
  localparam logic [5:0] OP_LH       = 6'h21;
  localparam logic [5:0] OP_LW       = 6'h23;
  localparam logic [5:0] OP_LBU      = 6'h24;
  localparam logic [5:0] OP_LHU      = 6'h25;
  localparam logic [5:0] OP_SB       = 6'h28;
  localparam logic [5:0] OP_SH       = 6'h29;
  localparam logic [5:0] OP_SW       = 6'h2B;

  localparam logic [5:0] FN_SLL     = 6'h00;
  localparam logic [5:0] FN_SRL     = 6'h02;
  localparam logic [5:0] FN_SRA     = 6'h03;
  localparam logic [5:0] FN_SLLV    = 6'h04;
  localparam logic [5:0] FN_SRLV    = 6'h06;
  localparam logic [5:0] FN_SRAV    = 6'h07;
  localparam logic [5:0] FN_JR      = 6'h08;
  localparam logic [5:0] FN_JALR    = 6'h09;
  localparam logic [5:0] FN_MOVZ    = 6'h0A;
  localparam logic [5:0] FN_MOVN    = 6'h0B;
  localparam logic [5:0] FN_SYSCALL = 6'h0C;
  localparam logic [5:0] FN_MFHI    = 6'h10;
  localparam logic [5:0] FN_MTHI    = 6'h11;
  localparam logic [5:0] FN_MFLO    = 6'h12;
  localparam logic [5:0] FN_MTLO    = 6'h13;
  localparam logic [5:0] FN_MULT    = 6'h18;
  localparam logic [5:0] FN_MULTU   = 6'h19;
  localparam logic [5:0] FN_DIV     = 6'h1A;
  localparam logic [5:0] FN_DIVU    = 6'h1B;
  localparam logic [5:0] FN_ADD     = 6'h20;
  localparam logic [5:0] FN_ADDU    = 6'h21;
  localparam logic [5:0] FN_SUB     = 6'h22;
  localparam logic [5:0] FN_SUBU    = 6'h23;
  localparam logic [5:0] FN_AND     = 6'h24;
  localparam logic [5:0] FN_OR      = 6'h25;
  localparam logic [5:0] FN_XOR     = 6'h26;
  localparam logic [5:0] FN_NOR     = 6'h27;
  localparam logic [5:0] FN_SLT     = 6'h2A;
  localparam logic [5:0] FN_SLTU    = 6'h2B;
  localparam logic [5:0] FN2_MUL    = 6'h02;

  localparam logic [4:0] RT_BLTZ   = 5'h00;
  localparam logic [4:0] RT_BGEZ   = 5'h01;
  localparam logic [4:0] RT_BLTZAL = 5'h10;
  localparam logic [4:0] RT_BGEZAL = 5'h11;

  localparam logic [4:0] RS_MFC0 = 5'h00;
  localparam logic [4:0] RS_MTC0 = 5'h04;

  localparam logic [4:0] REG_RA = 5'd31;

  typedef struct packed {
    logic [CLS_W-1:0] cls;
    logic             rs_use;
    logic             rt_use;
    logic [REG_W-1:0] wdst;
    logic             wen;
  } predec_t;

  typedef struct packed {
    logic [XLEN-1:0] instr;
    logic [XLEN-1:0] pc;
    logic            pred_taken;
    predec_t         dec;
  } entry_t;

endpackage

// File: rtl/id_decode_queue_predecode.sv
// Combinational predecode: instruction word -> class, source-use flags and
// destination register.
module id_predecode
  import id_decode_queue_pkg::*;
(
  input  logic [XLEN-1:0]  instr,
  output logic [CLS_W-1:0] cls_c,
  output logic             rs_use_c,
  output logic             rt_use_c,
  output logic [REG_W-1:0] wdst_c,
  output logic             wen_c
);

  logic [5:0]       op;
  logic [5:0]       fn;
  logic [REG_W-1:0] rs;
  logic [REG_W-1:0] rt;
  logic [REG_W-1:0] rd;
  logic             has_dst;
  logic [REG_W-1:0] dst;
  logic             unused_shamt;

  assign op           = instr[31:26];
  assign rs           = instr[25:21];
  assign rt           = instr[20:16];
  assign rd           = instr[15:11];
  assign fn           = instr[5:0];
  assign unused_shamt = ^instr[10:6];

  always_comb begin
    cls_c    = '0;
    rs_use_c = 1'b1;
    rt_use_c = 1'b0;
    has_dst  = 1'b0;
    dst      = '0;
    case (op)
      OP_SPECIAL: begin
        case (fn)
          FN_SLL, FN_SRL, FN_SRA: begin
            rs_use_c = 1'b0;
            rt_use_c = 1'b1;
            has_dst  = 1'b1;
            dst      = rd;
          end
          FN_SLLV, FN_SRLV, FN_SRAV, FN_MOVZ, FN_MOVN,
          FN_ADD, FN_ADDU, FN_SUB, FN_SUBU, FN_AND, FN_OR,
          FN_XOR, FN_NOR, FN_SLT, FN_SLTU: begin
            rt_use_c = 1'b1;
            has_dst  = 1'b1;
            dst      = rd;
          end
          FN_JR: cls_c[CLS_BRANCH] = 1'b1;
          FN_JALR: begin
            cls_c[CLS_BRANCH] = 1'b1;
            has_dst           = 1'b1;
            dst               = rd;
          end
          FN_SYSCALL: rs_use_c = 1'b0;
          FN_MFHI, FN_MFLO: begin
            cls_c[CLS_MDU] = 1'b1;
            rs_use_c       = 1'b0;
            has_dst        = 1'b1;
            dst            = rd;
          end
          FN_MTHI, FN_MTLO: cls_c[CLS_MDU] = 1'b1;
          FN_MULT, FN_MULTU, FN_DIV, FN_DIVU: begin
            cls_c[CLS_MDU] = 1'b1;
            rt_use_c       = 1'b1;
          end
          default: ;
        endcase
      end
      OP_REGIMM: begin
        case (rt)
          RT_BLTZ, RT_BGEZ: cls_c[CLS_BRANCH] = 1'b1;
          RT_BLTZAL, RT_BGEZAL: begin
            cls_c[CLS_BRANCH] = 1'b1;
            has_dst           = 1'b1;
            dst               = REG_RA;
          end
          default: ;
        endcase
      end
      OP_J: begin
        cls_c[CLS_BRANCH] = 1'b1;
        rs_use_c          = 1'b0;
      end
      OP_JAL: begin
        cls_c[CLS_BRANCH] = 1'b1;
        rs_use_c          = 1'b0;
        has_dst           = 1'b1;
        dst               = REG_RA;
      end
      OP_BEQ, OP_BNE: begin
        cls_c[CLS_BRANCH] = 1'b1;
        rt_use_c          = 1'b1;
      end
      OP_BLEZ, OP_BGTZ: cls_c[CLS_BRANCH] = 1'b1;
      OP_COP0: begin
        rs_use_c = 1'b0;
        if (rs == RS_MFC0) begin
          has_dst = 1'b1;
          dst     = rt;
        end
        if (rs == RS_MTC0) rt_use_c = 1'b1;
      end
      OP_SPECIAL2: begin
        if (fn == FN2_MUL) begin
          cls_c[CLS_MDU] = 1'b1;
          rt_use_c       = 1'b1;
          has_dst        = 1'b1;
          dst            = rd;
        end
      end
      OP_LB, OP_LH, OP_LW, OP_LBU, OP_LHU: begin
        cls_c[CLS_LOAD] = 1'b1;
        has_dst         = 1'b1;
        dst             = rt;
      end
      OP_SB, OP_SH, OP_SW: begin
        cls_c[CLS_STORE] = 1'b1;
        rt_use_c         = 1'b1;
      end
      default: begin
        // 001xxx: I-type arithmetic, writes rt; LUI has no rs operand
        if (op[5:3] == 3'b001) begin
          has_dst = 1'b1;
          dst     = rt;
        end
        if (op == OP_LUI) rs_use_c = 1'b0;
      end
    endcase
  end

  // A write to $0 is architecturally a no-op, so it never enables the port
  assign wen_c  = has_dst && (dst != '0);
  assign wdst_c = has_dst ? dst : '0;

endmodule

// File: rtl/id_decode_queue.sv
// IF->ID instruction queue with predecode on enqueue and load-use/MDU issue
// interlocks. Define ID_QUEUE_BYPASS_EN to forward into an empty queue.
module id_decode_queue
  import id_decode_queue_pkg::*;
#(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned CNT_W = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_instr,
  input  logic [31:0]      in_pc,
  input  logic             in_pred_taken,
  input  logic             flush_i,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_instr,
  output logic [31:0]      out_pc,
  output logic             out_pred_taken,
  output logic [3:0]       out_class,
  output logic             out_rs_use,
  output logic             out_rt_use,
  output logic [4:0]       out_wdst,
  output logic             out_wen,
  input  logic             ex_load_valid,
  input  logic [4:0]       ex_load_dst,
  input  logic             mdu_busy_i,
  output logic             stall_o,
  output logic [CNT_W-1:0] count_o
);

  localparam int unsigned PTR_W = $clog2(DEPTH);

  entry_t           mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q;
  logic [PTR_W-1:0] rd_ptr_q;
  logic [CNT_W-1:0] count_q;

  predec_t dec_c;
  entry_t  in_entry;
  entry_t  head;
  logic    empty;
  logic    full;
  logic    bypass;
  logic    head_present;
  logic    load_use;
  logic    hazard;
  logic    push;
  logic    pop;
  logic    push_q;
  logic    pop_q;

  id_predecode u_predecode (
    .instr    (in_instr),
    .cls_c    (dec_c.cls),
    .rs_use_c (dec_c.rs_use),
    .rt_use_c (dec_c.rt_use),
    .wdst_c   (dec_c.wdst),
    .wen_c    (dec_c.wen)
  );

  always_comb begin
    in_entry            = '0;
    in_entry.instr      = in_instr;
    in_entry.pc         = in_pc;
    in_entry.pred_taken = in_pred_taken;
    in_entry.dec        = dec_c;
  end

  assign empty = (count_q == '0);
  assign full  = (count_q == CNT_W'(DEPTH));

`ifdef ID_QUEUE_BYPASS_EN
  assign bypass = empty && in_valid && !flush_i;
`else
  assign bypass = 1'b0;
`endif

  assign head_present = !empty || bypass;

  // Head selection: stored oldest entry, forwarded input, or all-zero
  always_comb begin
    head = '0;
    if (!empty)      head = mem[rd_ptr_q];
    else if (bypass) head = in_entry;
  end

  assign load_use = ex_load_valid && (ex_load_dst != '0) &&
                    ((head.dec.rs_use && (head.instr[25:21] == ex_load_dst)) ||
                     (head.dec.rt_use && (head.instr[20:16] == ex_load_dst)));
  assign hazard   = load_use || (head.dec.cls[CLS_MDU] && mdu_busy_i);

  assign out_valid = head_present && !hazard && !flush_i;
  assign stall_o   = head_present &&  hazard && !flush_i;
  assign in_ready  = !full;
  assign count_o   = count_q;

  assign out_instr      = head.instr;
  assign out_pc         = head.pc;
  assign out_pred_taken = head.pred_taken;
  assign out_class      = head.dec.cls;
  assign out_rs_use     = head.dec.rs_use;
  assign out_rt_use     = head.dec.rt_use;
  assign out_wdst       = head.dec.wdst;
  assign out_wen        = head.dec.wen;

  assign push = in_valid && in_ready && !flush_i;
  assign pop  = out_valid && out_ready;
  // A forwarded instruction consumed this cycle never occupies a slot
  assign push_q = push && !(bypass && pop);
  assign pop_q  = pop && !bypass;

  // Pointer and occupancy state
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else if (flush_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_q) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (pop_q)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      case ({push_q, pop_q})
        2'b10:   count_q <= count_q + CNT_W'(1);
        2'b01:   count_q <= count_q - CNT_W'(1);
        default: ;
      endcase
    end
  end

  // Entry storage carries no reset
  always_ff @(posedge clk) begin
    if (push_q) mem[wr_ptr_q] <= in_entry;
  end

endmodule
